// File: rtl/gcd_ctrl.sv
// gcd_ctrl: control FSM for a 16-bit subtractive GCD datapath.
//
// The FSM loads operand A and then operand B from data_in. It then repeatedly
// subtracts the smaller datapath register from the larger one until the
// comparator reports equality. It aborts with a sticky err flag when the
// flags are inconsistent, or when MAX_ITER subtractions have not converged.
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   start          request a new computation (sampled in IDLE only)
//   lt, gt, eq     datapath comparator flags (A<B, A>B, A==B)
//   ldA, ldB       datapath register load enables
//   sel1, sel2     subtractor minuend / subtrahend selects (0 = A, 1 = B)
//   sel_in         register input select (0 = subtractor, 1 = data_in)
//   busy           high in every state except IDLE
//   done           one-cycle pulse, result valid in A and B
//   err            sticky abort flag, cleared by the next accepted start
//   iter_count     subtractions performed in the current or last run
module gcd_ctrl #(
  parameter int unsigned ITER_W   = 16,
  parameter int unsigned MAX_ITER = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              lt,
  input  logic              gt,
  input  logic              eq,
  output logic              ldA,
  output logic              ldB,
  output logic              sel1,
  output logic              sel2,
  output logic              sel_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ITER_W-1:0] iter_count
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoadA = 3'd1;
  localparam logic [2:0] StLoadB = 3'd2;
  localparam logic [2:0] StCheck = 3'd3;
  localparam logic [2:0] StSubA  = 3'd4;
  localparam logic [2:0] StSubB  = 3'd5;
  localparam logic [2:0] StDone  = 3'd6;
  localparam logic [2:0] StErr   = 3'd7;

  localparam logic [ITER_W-1:0] IterLimit = ITER_W'(MAX_ITER);

  logic [2:0]        state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              err_q, err_d;
  logic              flags_onehot;

  assign flags_onehot = $onehot({lt, gt, eq});

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoadA;
          iter_d  = '0;
          err_d   = 1'b0;
        end
      end
      StLoadA: state_d = StLoadB;
      StLoadB: state_d = StCheck;
      StCheck: begin
        // The iteration limit is tested before any further increment, so
        // iter_count can never wrap.
        if (!flags_onehot) begin
          state_d = StErr;
        end else if (eq) begin
          state_d = StDone;
        end else if (iter_q == IterLimit) begin
          state_d = StErr;
        end else if (gt) begin
          state_d = StSubA;
        end else begin
          state_d = StSubB;
        end
        // err rises as ERR is entered and stays set through IDLE.
        if (state_d == StErr) begin
          err_d = 1'b1;
        end
      end
      StSubA, StSubB: begin
        iter_d  = iter_q + 1'b1;
        state_d = StCheck;
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      iter_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      err_q   <= err_d;
    end
  end

  // Moore outputs decoded from the state register only.
  always_comb begin
    ldA    = 1'b0;
    ldB    = 1'b0;
    sel1   = 1'b0;
    sel2   = 1'b0;
    sel_in = 1'b0;
    done   = 1'b0;
    unique case (state_q)
      StLoadA: begin
        ldA    = 1'b1;
        sel_in = 1'b1;
      end
      StLoadB: begin
        ldB    = 1'b1;
        sel_in = 1'b1;
      end
      StSubA: begin
        ldA  = 1'b1;
        sel2 = 1'b1;
      end
      StSubB: begin
        ldB  = 1'b1;
        sel1 = 1'b1;
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  assign busy       = (state_q != StIdle);
  assign err        = err_q;
  assign iter_count = iter_q;

endmodule

// File: tb/tb_gcd_ctrl.sv
// tb_gcd_ctrl: drives gcd_ctrl against a behavioural datapath and checks it
// against an arithmetic GCD reference model.
module tb_gcd_ctrl;

  localparam int MaxIter = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        lt, gt, eq;
  logic        ldA, ldB, sel1, sel2, sel_in, busy, done, err;
  logic [15:0] iter_count;

  logic [15:0] op_a = '0, op_b = '0;
  logic [15:0] dp_a = '0, dp_b = '0;
  logic [15:0] data_in, sub;
  logic        force_bad = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gcd_ctrl #(.ITER_W(16), .MAX_ITER(MaxIter)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .lt         (lt),
    .gt         (gt),
    .eq         (eq),
    .ldA        (ldA),
    .ldB        (ldB),
    .sel1       (sel1),
    .sel2       (sel2),
    .sel_in     (sel_in),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .iter_count (iter_count)
  );

  // Behavioural datapath: upstream presents A during LOAD_A, B during LOAD_B.
  assign data_in = ldA ? op_a : op_b;
  assign sub     = (sel1 ? dp_b : dp_a) - (sel2 ? dp_b : dp_a);
  assign lt      = force_bad ? 1'b1 : (dp_a < dp_b);
  assign gt      = force_bad ? 1'b1 : (dp_a > dp_b);
  assign eq      = force_bad ? 1'b0 : (dp_a == dp_b);

  always @(posedge clk) begin
    if (ldA) dp_a <= sel_in ? data_in : sub;
    if (ldB) dp_b <= sel_in ? data_in : sub;
  end

  // Reference: subtract the smaller from the larger until equal; give up
  // once the limit is reached without equality.
  function automatic void ref_gcd(input int a, input int b, output int n, output bit e,
                                  output int g);
    n = 0;
    e = 1'b0;
    while (a != b) begin
      if (n == MaxIter) begin
        e = 1'b1;
        break;
      end
      if (a > b) a = a - b;
      else b = b - a;
      n++;
    end
    g = a;
  endfunction

  // Runs one computation from IDLE. start is re-driven for cycles hold_lo..hold_hi.
  // On return the bench sits at the negedge of the first IDLE cycle after the run.
  task automatic run_gcd(input string name, input int a, input int b, input bit bad,
                         input int hold_lo, input int hold_hi);
    int  exp_n, exp_g, last_busy, done_cnt, done_cyc, ld_after;
    bit  exp_e, finished;
    exp_n = 0;
    exp_e = 1'b0;
    exp_g = 0;
    if (bad) exp_e = 1'b1;
    else ref_gcd(a, b, exp_n, exp_e, exp_g);
    op_a      = 16'(a);
    op_b      = 16'(b);
    force_bad = bad;
    last_busy = -1;
    done_cnt  = 0;
    done_cyc  = -1;
    ld_after  = 0;
    finished  = 1'b0;
    start     = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        checks++;
        if ({ldA, sel_in, busy, err} !== 4'b1110) begin
          errors++;
          $display("FAIL %s load_a: ldA/sel_in/busy/err=%b required 1110", name,
                   {ldA, sel_in, busy, err});
        end
      end
      if (!busy) begin
        last_busy = c - 1;
        finished  = 1'b1;
        break;
      end
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (c >= 3 && (ldA || ldB)) ld_after++;
      start = (c + 1 >= hold_lo) && (c + 1 <= hold_hi);
    end
    force_bad = 1'b0;
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL %s timeout: still busy after 200 cycles", name);
      return;
    end
    checks++;
    if (last_busy != 4 + 2 * exp_n) begin
      errors++;
      $display("FAIL %s latency: last busy cycle %0d required %0d", name, last_busy,
               4 + 2 * exp_n);
    end
    checks++;
    if (done_cnt != (exp_e ? 0 : 1) || (!exp_e && done_cyc != 4 + 2 * exp_n)) begin
      errors++;
      $display("FAIL %s done: count %0d at cycle %0d required %0d at %0d", name, done_cnt,
               done_cyc, exp_e ? 0 : 1, 4 + 2 * exp_n);
    end
    checks++;
    if (err !== exp_e) begin
      errors++;
      $display("FAIL %s err: %b required %b", name, err, exp_e);
    end
    checks++;
    if (iter_count !== 16'(exp_n)) begin
      errors++;
      $display("FAIL %s iter_count: %0d required %0d", name, iter_count, exp_n);
    end
    checks++;
    if (ld_after != exp_n) begin
      errors++;
      $display("FAIL %s loads: %0d loads after LOAD_B required %0d", name, ld_after, exp_n);
    end
    if (!exp_e) begin
      checks++;
      if (dp_a !== 16'(exp_g) || dp_b !== 16'(exp_g)) begin
        errors++;
        $display("FAIL %s result: A=%0d B=%0d required %0d", name, dp_a, dp_b, exp_g);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({ldA, ldB, sel1, sel2, sel_in, busy, done, err, iter_count} !== '0) begin
      errors++;
      $display("FAIL reset_state: outputs=%b iter=%0d required all zero",
               {ldA, ldB, sel1, sel2, sel_in, busy, done, err}, iter_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_gcd("gcd_48_18", 48, 18, 1'b0, 0, -1);
    run_gcd("gcd_7_7", 7, 7, 1'b0, 0, -1);
  endtask

  task automatic test_iter_limit();
    run_gcd("zero_operand", 0, 5, 1'b0, 0, -1);
    repeat (3) @(negedge clk);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL err_sticky: err=%b busy=%b required err=1 busy=0", err, busy);
    end
    // The next run checks in its first cycle that start cleared err.
    run_gcd("after_err", 21, 14, 1'b0, 0, -1);
  endtask

  task automatic test_bad_flags();
    run_gcd("flags_not_onehot", 20, 8, 1'b1, 0, -1);
  endtask

  task automatic test_reset_mid_run();
    bit hit;
    hit       = 1'b0;
    op_a      = 16'd48;
    op_b      = 16'd18;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (ldA && !sel_in) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reset_mid: SUB_A never reached");
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ldA, ldB, sel1, sel2, sel_in, busy, done, err, iter_count} !== '0) begin
      errors++;
      $display("FAIL reset_mid: outputs=%b iter=%0d required all zero",
               {ldA, ldB, sel1, sel2, sel_in, busy, done, err}, iter_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_gcd("after_reset", 21, 14, 1'b0, 0, -1);
  endtask

  task automatic test_back_to_back();
    run_gcd("start_ignored", 48, 18, 1'b0, 2, 10);
    // start in the IDLE cycle right after a run must launch a new one.
    run_gcd("idle_restart", 9, 6, 1'b0, 0, -1);
    // start held through DONE relaunches from the following IDLE cycle.
    run_gcd("held_start", 10, 4, 1'b0, 1, 1000);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({ldA, sel_in, busy} !== 3'b111) begin
      errors++;
      $display("FAIL held_start_relaunch: ldA/sel_in/busy=%b required 111",
               {ldA, sel_in, busy});
    end
    for (int c = 0; c < 100 && busy; c++) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL held_start_finish: busy=%b required 0", busy);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      run_gcd("random", int'($urandom_range(0, 40)), int'($urandom_range(1, 40)), 1'b0, 0,
              -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_iter_limit();
    test_bad_flags();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
